mips_cpu_seq_ctrl: RTL
======================

MIPS_CPU_SEQ_CTRL -- requirements
Module: mips_cpu_seq_ctrl

Interface
REQ-001 Parameter HALT_ADDR, default 32'h00000000: an instruction fetch from this PC value halts the CPU.
REQ-002 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-low reset.
REQ-004 Port waitrequest  input  1  memory busy; the current read or write has not completed while high.
REQ-005 Port pc  input  32  current PC value from the PC block.
REQ-006 Port is_load  input  1  decoded instruction is a load; valid in EXEC.
REQ-007 Port is_store  input  1  decoded instruction is a store; valid in EXEC.
REQ-008 Port reg_wr_req  input  1  decoded non-load instruction writes the register file; valid in EXEC.
REQ-009 Port mem_read  output  1  memory read strobe.
REQ-010 Port mem_write  output  1  memory write strobe.
REQ-011 Port addr_sel  output  1  memory address mux select: 0 = pc, 1 = data address.
REQ-012 Port ir_load  output  1  instruction register capture strobe.
REQ-013 Port pc_en  output  1  single-cycle PC advance enable to the PC block.
REQ-014 Port reg_write  output  1  register file write strobe.
REQ-015 Port active  output  1  high unless in IDLE or HALT.
REQ-016 Port state  output  3  current FSM state encoding.
REQ-017 Port instr_count  output  32  count of retired instructions.

Function
REQ-018 States and encodings SHALL be: IDLE=0, FETCH=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB=5, HALT=6. Code 7 SHALL transition to IDLE.
REQ-019 All strobes SHALL be Moore outputs decoded from state only, except the FETCH halt gating in REQ-021 and the ir_load gating in REQ-022.
REQ-020 IDLE: all strobes 0 -> FETCH on the next edge.
REQ-021 FETCH, pc==HALT_ADDR: mem_read=0 -> HALT on the next edge.
REQ-022 FETCH, otherwise: mem_read=1, addr_sel=0.
  - waitrequest=1: stay in FETCH, ir_load=0.
  - waitrequest=0: ir_load=1 for that cycle -> EXEC.
REQ-023 EXEC: pc_en=1 for exactly one cycle; next state by priority:
  - is_load -> MEM_RD (load wins if is_load and is_store are both set);
  - else is_store -> MEM_WR;
  - else reg_wr_req -> WB;
  - else FETCH.
REQ-024 MEM_RD: mem_read=1, addr_sel=1; hold while waitrequest=1; -> WB when waitrequest=0.
REQ-025 MEM_WR: mem_write=1, addr_sel=1; hold while waitrequest=1; -> FETCH when waitrequest=0.
REQ-026 WB: reg_write=1 for one cycle -> FETCH.
REQ-027 HALT: all strobes 0, active=0; stay in HALT until reset.
REQ-028 mem_read and mem_write SHALL never be high in the same cycle.
REQ-029 instr_count SHALL increment by 1 on each cycle spent in EXEC, wrap 32'hFFFFFFFF -> 0, and hold in all other states.
REQ-030 Minimum latencies with waitrequest=0: ALU no-writeback 2 cycles, ALU writeback 3, load 4, store 3; each waitrequest cycle adds exactly one cycle.
REQ-031 Branch delay slots SHALL need no special handling: the PC block sequences them through ordinary pc_en pulses.

Reset
REQ-032 When reset=0 at a rising edge: state SHALL become IDLE and instr_count 0; all strobes and active SHALL be 0 in the following cycle.
REQ-033 Reset SHALL take priority in every state, including mid-wait in FETCH, MEM_RD or MEM_WR; the aborted access SHALL not resume.
REQ-034 Held reset=0 SHALL keep the block in IDLE with all strobes 0.

Verification
REQ-035 Release reset, waitrequest=0, pc=32'hBFC00000, no decode flags -> IDLE, FETCH (mem_read=1, ir_load=1), EXEC (pc_en=1), FETCH; instr_count=1.
REQ-036 FETCH with waitrequest high for 3 cycles -> mem_read held 4 cycles, ir_load only in the 4th, then EXEC.
REQ-037 EXEC with is_load=1 and is_store=1 -> MEM_RD (mem_read=1, addr_sel=1, mem_write=0), then WB (reg_write=1), then FETCH.
REQ-038 Store with waitrequest high 2 cycles -> mem_write high 3 cycles, then FETCH; reg_write never asserted.
REQ-039 pc=HALT_ADDR on entry to FETCH -> HALT next cycle, mem_read never asserted, active=0; remains in HALT for 10+ cycles until reset=0.
REQ-040 reset=0 during MEM_RD wait -> next cycle IDLE with mem_read=0 and instr_count=0; instr_count 32'hFFFFFFFF plus one EXEC -> 0.

Source files
------------

// File: rtl/mips_cpu_seq_ctrl.sv
// Multi-cycle MIPS sequencing controller: drives fetch/execute/memory/writeback
// strobes from a seven-state FSM and counts retired instructions.
module mips_cpu_seq_ctrl #(
    parameter logic [31:0] HALT_ADDR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [31:0] pc,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        reg_wr_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        addr_sel,
    output logic        ir_load,
    output logic        pc_en,
    output logic        reg_write,
    output logic        active,
    output logic [2:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_MEM_WR = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_RSVD   = 3'd7
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] instr_count_r;
    logic        halt_hit_s;

    assign halt_hit_s  = (pc == HALT_ADDR);
    assign state       = state_r;
    assign instr_count = instr_count_r;

    // State register; a low reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Retired-instruction counter: one tick per EXEC cycle, wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_count_r <= 32'd0;
        end else if (state_r == ST_EXEC) begin
            instr_count_r <= instr_count_r + 32'd1;
        end else begin
            instr_count_r <= instr_count_r;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (halt_hit_s) begin
                    state_next_s = ST_HALT;
                end else if (waitrequest) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Load outranks store when a bad decode asserts both.
                if (is_load) begin
                    state_next_s = ST_MEM_RD;
                end else if (is_store) begin
                    state_next_s = ST_MEM_WR;
                end else if (reg_wr_req) begin
                    state_next_s = ST_WB;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_MEM_RD: begin
                if (waitrequest) begin
                    state_next_s = ST_MEM_RD;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_MEM_WR: begin
                if (waitrequest) begin
                    state_next_s = ST_MEM_WR;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_WB: begin
                state_next_s = ST_FETCH;
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Strobe decode from the state register; FETCH also looks at pc and waitrequest.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_sel  = 1'b0;
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        reg_write = 1'b0;
        active    = 1'b1;
        case (state_r)
            ST_IDLE: begin
                active = 1'b0;
            end
            ST_FETCH: begin
                if (halt_hit_s) begin
                    mem_read = 1'b0;
                end else begin
                    mem_read = 1'b1;
                    ir_load  = ~waitrequest;
                end
            end
            ST_EXEC: begin
                pc_en = 1'b1;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                addr_sel = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                addr_sel  = 1'b1;
            end
            ST_WB: begin
                reg_write = 1'b1;
            end
            ST_HALT: begin
                active = 1'b0;
            end
            default: begin
                active = 1'b1;
            end
        endcase
    end

endmodule
